// File: rtl/studio2_dma_ctl.sv
// studio2_dma_ctl: DMA-out fetch controller for the 1861 video generator (IDLE/ADDR/WAIT/DATA).
// Define DMA_VRAM_WINDOW_EN to confine the pointer to the 0x900-0x9FF video window.
module studio2_dma_ctl (
    input  logic        clk,
    input  logic        resetq,
    input  logic        clk_enable,
    input  logic        dma_req,
    input  logic        ptr_load,
    input  logic [11:0] ptr_value,
    output logic        mem_rd,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_q,
    output logic [7:0]  dma_data,
    output logic        dma_valid,
    output logic        cpu_stall,
    output logic [11:0] ptr,
    output logic        line_end,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_DATA
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [11:0] r_ptr;
    logic [2:0]  r_byte_cnt;
    logic [7:0]  r_dma_data;
    logic        r_skip_inc;
    logic        r_overrun;
    logic        w_req;
    logic [11:0] w_ptr_inc;
    logic [11:0] w_ptr_load_val;

    assign w_req = clk_enable & dma_req;

`ifdef DMA_VRAM_WINDOW_EN
    localparam logic [11:0] PTR_RESET = 12'h900;
    logic w_unused_ptr_hi;
    assign w_unused_ptr_hi = ^ptr_value[11:8];
    assign w_ptr_load_val  = {4'h9, ptr_value[7:0]};
    assign w_ptr_inc       = {4'h9, r_ptr[7:0] + 8'd1};
`else
    localparam logic [11:0] PTR_RESET = 12'h000;
    assign w_ptr_load_val  = ptr_value;
    assign w_ptr_inc       = r_ptr + 12'd1;
`endif

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_next_state = S_ADDR;
            S_ADDR:  w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_DATA;
            S_DATA:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_addr  = 12'h000;
        cpu_stall = 1'b0;
        dma_valid = 1'b0;
        line_end  = 1'b0;
        case (r_state)
            S_ADDR: begin
                mem_rd    = 1'b1;
                mem_addr  = r_ptr;
                cpu_stall = 1'b1;
            end
            S_WAIT: begin
                cpu_stall = 1'b1;
            end
            S_DATA: begin
                cpu_stall = 1'b1;
                dma_valid = 1'b1;
                line_end  = (r_byte_cnt == 3'd7);
            end
            default: begin
                cpu_stall = 1'b0;
            end
        endcase
    end

    // A reload while a fetch is in flight suppresses that fetch's pointer increment.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_ptr      <= PTR_RESET;
            r_byte_cnt <= 3'd0;
            r_skip_inc <= 1'b0;
        end else begin
            if (ptr_load) begin
                r_ptr      <= w_ptr_load_val;
                r_byte_cnt <= 3'd0;
            end else if (r_state == S_DATA) begin
                r_byte_cnt <= r_byte_cnt + 3'd1;
                if (!r_skip_inc) begin
                    r_ptr <= w_ptr_inc;
                end
            end

            if (r_state == S_DATA) begin
                r_skip_inc <= 1'b0;
            end else if (ptr_load && (r_state == S_ADDR || r_state == S_WAIT)) begin
                r_skip_inc <= 1'b1;
            end
        end
    end

    // mem_q is valid during WAIT, so it is captured on the WAIT->DATA edge.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_dma_data <= 8'h00;
            r_overrun  <= 1'b0;
        end else begin
            if (r_state == S_WAIT) begin
                r_dma_data <= mem_q;
            end
            if (w_req && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign dma_data = r_dma_data;
    assign ptr      = r_ptr;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_studio2_dma_ctl.sv
// tb_studio2_dma_ctl: randomized and directed bench for studio2_dma_ctl against a fetch-level model.
// Honours DMA_VRAM_WINDOW_EN the same way as the design.
module tb_studio2_dma_ctl;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        clkEnable = 1'b0;
    logic        dmaReq = 1'b0;
    logic        ptrLoad = 1'b0;
    logic [11:0] ptrValue = 12'h000;
    logic        memRd;
    logic [11:0] memAddr;
    logic [7:0]  memQ = 8'h00;
    logic [7:0]  dmaData;
    logic        dmaValid;
    logic        cpuStall;
    logic [11:0] ptr;
    logic        lineEnd;
    logic        overrun;

    int checks = 0;
    int fails = 0;
    int validSeen = 0;
    int lineEndSeen = 0;

    // Fetch-level reference: phase counts cycles since acceptance (0 = idle)
    int          mPhase;
    logic [11:0] mPtr;
    int          mCnt;
    bit          mOverrun;
    bit          mReloaded;
    logic [11:0] mFetchAddr;
    logic [7:0]  mData;

`ifdef DMA_VRAM_WINDOW_EN
    localparam logic [11:0] RESET_PTR = 12'h900;
    localparam logic [11:0] WRAP_LOAD = 12'h3FF;
    localparam logic [11:0] WRAP_ADDR = 12'h9FF;
    localparam logic [11:0] WRAP_PTR  = 12'h900;
`else
    localparam logic [11:0] RESET_PTR = 12'h000;
    localparam logic [11:0] WRAP_LOAD = 12'hFFF;
    localparam logic [11:0] WRAP_ADDR = 12'hFFF;
    localparam logic [11:0] WRAP_PTR  = 12'h000;
`endif

    studio2_dma_ctl dut (
        .clk        (clk),
        .resetq     (resetq),
        .clk_enable (clkEnable),
        .dma_req    (dmaReq),
        .ptr_load   (ptrLoad),
        .ptr_value  (ptrValue),
        .mem_rd     (memRd),
        .mem_addr   (memAddr),
        .mem_q      (memQ),
        .dma_data   (dmaData),
        .dma_valid  (dmaValid),
        .cpu_stall  (cpuStall),
        .ptr        (ptr),
        .line_end   (lineEnd),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Memory returns addr[7:0] one cycle after a read, garbage otherwise
    always @(posedge clk) begin
        memQ <= memRd ? memAddr[7:0] : 8'($urandom);
    end

    function automatic logic [11:0] modelLoad(input logic [11:0] v);
`ifdef DMA_VRAM_WINDOW_EN
        return 12'h900 + {4'h0, v[7:0]};
`else
        return v;
`endif
    endfunction

    function automatic logic [11:0] modelInc(input logic [11:0] p);
`ifdef DMA_VRAM_WINDOW_EN
        return 12'(32'h900 + ((int'(p) - 32'h900 + 1) % 256));
`else
        return 12'((int'(p) + 1) % 4096);
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        mPhase     = 0;
        mPtr       = RESET_PTR;
        mCnt       = 0;
        mOverrun   = 0;
        mReloaded  = 0;
        mFetchAddr = 12'h000;
        mData      = 8'h00;
    endtask

    task automatic modelStep(input bit ce, input bit req, input bit load, input logic [11:0] val);
        bit accept;
        accept = ce && req && (mPhase == 0);
        if (ce && req && mPhase != 0) mOverrun = 1;
        if (mPhase == 3) begin
            if (!load && !mReloaded) mPtr = modelInc(mPtr);
            mCnt = (mCnt + 1) % 8;
        end
        if (load) begin
            if (mPhase == 1 || mPhase == 2) mReloaded = 1;
            mPtr = modelLoad(val);
            mCnt = 0;
        end
        if (mPhase == 2) mData = mFetchAddr[7:0];
        if (accept) begin
            mPhase     = 1;
            mFetchAddr = mPtr;
            mReloaded  = 0;
        end else if (mPhase == 3) begin
            mPhase = 0;
        end else if (mPhase != 0) begin
            mPhase++;
        end
    endtask

    task automatic compareAll();
        checkOutput("mem_rd",    memRd,    (mPhase == 1));
        checkOutput("mem_addr",  memAddr,  (mPhase == 1) ? mFetchAddr : 12'h000);
        checkOutput("cpu_stall", cpuStall, (mPhase != 0));
        checkOutput("dma_valid", dmaValid, (mPhase == 3));
        checkOutput("line_end",  lineEnd,  (mPhase == 3 && mCnt == 7));
        checkOutput("dma_data",  dmaData,  mData);
        checkOutput("ptr",       ptr,      mPtr);
        checkOutput("overrun",   overrun,  mOverrun);
        if (dmaValid) validSeen++;
        if (lineEnd) lineEndSeen++;
    endtask

    // One clock: drive inputs, advance the model at the edge, check on the falling edge
    task automatic applyStimulus(input bit ce, input bit req, input bit load, input logic [11:0] val);
        clkEnable = ce;
        dmaReq    = req;
        ptrLoad   = load;
        ptrValue  = val;
        @(posedge clk);
        modelStep(ce, req, load, val);
        @(negedge clk);
        clkEnable = 1'b0;
        dmaReq    = 1'b0;
        ptrLoad   = 1'b0;
        compareAll();
    endtask

    task automatic doReset();
        resetq = 1'b0;
        modelReset();
        repeat (2) begin
            @(negedge clk);
            compareAll();
        end
        resetq = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 12'h000);
    endtask

    initial begin
        doReset();

        // Eight spaced requests form one line
        applyStimulus(0, 0, 1, 12'h900);
        validSeen = 0;
        lineEndSeen = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 0, 12'h000);
            idle(4);
        end
        checkOutput("line_ptr", ptr, 12'h908);
        checkOutput("line_valids", validSeen, 8);
        checkOutput("line_end_count", lineEnd ? 99 : lineEndSeen, 1);
        checkOutput("line_last_data", dmaData, 8'h07);

        // Latency from acceptance
        applyStimulus(1, 1, 0, 12'h000);
        checkOutput("lat_rd_t1", {memRd, cpuStall, memAddr}, {1'b1, 1'b1, 12'h908});
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("lat_t2", {cpuStall, dmaValid, memRd}, 3'b100);
        applyStimulus(0, 0, 0, 12'h000);
        checkOutput("lat_valid_t3", {cpuStall, dmaValid}, 2'b11);
        idle(2);
        checkOutput("lat_idle_stall", cpuStall, 1'b0);

        // Pointer wrap
        applyStimulus(0, 0, 1, WRAP_LOAD);
        applyStimulus(1, 1, 0, 12'h000);
        checkOutput("wrap_addr", memAddr, WRAP_ADDR);
        idle(4);
        checkOutput("wrap_ptr", ptr, WRAP_PTR);

        // Request during WAIT is lost and flagged
        validSeen = 0;
        applyStimulus(1, 1, 0, 12'h000);
        applyStimulus(0, 0, 0, 12'h000);
        applyStimulus(1, 1, 0, 12'h000);
        idle(5);
        checkOutput("ovr_valids", validSeen, 1);
        checkOutput("ovr_sticky", overrun, 1'b1);
        doReset();
        checkOutput("ovr_cleared", overrun, 1'b0);

        // Reload during WAIT keeps in-flight address, no increment
        applyStimulus(0, 0, 1, 12'h910);
        applyStimulus(1, 1, 0, 12'h000);
        applyStimulus(0, 0, 0, 12'h000);
        applyStimulus(0, 0, 1, 12'h950);
        checkOutput("reload_data", dmaData, 8'h10);
        idle(3);
        checkOutput("reload_ptr", ptr, 12'h950);

        // Reset asserted while in ADDR
        applyStimulus(1, 1, 0, 12'h000);
        resetq = 1'b0;
        #1;
        checkOutput("rst_addr_outs", {memRd, cpuStall, dmaValid, lineEnd, overrun, memAddr, dmaData},
                    37'h0);
        checkOutput("rst_addr_ptr", ptr, RESET_PTR);
        modelReset();
        validSeen = 0;
        @(negedge clk);
        resetq = 1'b1;
        idle(4);
        checkOutput("rst_no_valid", validSeen, 0);
        applyStimulus(1, 1, 0, 12'h000);
        checkOutput("rst_first_req", memRd, 1'b1);
        idle(3);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                          1'($urandom_range(0, 15) == 0), 12'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/studio2_dma_ctl.md
STUDIO2_DMA_CTL -- requirements
Module: studio2_dma_ctl

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have port resetq  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port clk_enable  input  1  pixel-rate enable; dma_req is sampled only when it is high.
REQ-004 SHALL have port dma_req  input  1  active-high DMA-out request from the 1861 video generator.
REQ-005 SHALL have port ptr_load  input  1  one-cycle strobe that loads the DMA pointer.
REQ-006 SHALL have port ptr_value  input  12  value for the DMA pointer.
REQ-007 SHALL have port mem_rd  output  1  memory read enable, one cycle per fetch.
REQ-008 SHALL have port mem_addr  output  12  memory address for the fetch.
REQ-009 SHALL have port mem_q  input  8  memory read data, valid one cycle after mem_rd.
REQ-010 SHALL have port dma_data  output  8  fetched byte presented to the video generator.
REQ-011 SHALL have port dma_valid  output  1  one-cycle strobe: dma_data is new.
REQ-012 SHALL have port cpu_stall  output  1  high while a fetch owns the memory bus.
REQ-013 SHALL have port ptr  output  12  current DMA pointer.
REQ-014 SHALL have port line_end  output  1  one-cycle strobe with the 8th byte of a line.
REQ-015 SHALL have port overrun  output  1  sticky flag: a request was lost.
REQ-016 SHALL use one clock (clk), with reset asynchronous and active-low on resetq.

Function
REQ-017 SHALL implement the states IDLE, ADDR, WAIT and DATA.
REQ-018 IDLE->ADDR SHALL occur when clk_enable and dma_req are both high; otherwise IDLE SHALL hold.
REQ-019 ADDR SHALL drive mem_rd=1 and mem_addr=ptr for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL last one cycle and then go to DATA.
REQ-021 DATA SHALL capture mem_q into dma_data, pulse dma_valid, increment ptr, and return to IDLE.
REQ-022 Latency from the accepted request cycle to dma_valid SHALL be exactly 3 clk cycles.
REQ-023 cpu_stall SHALL be high in ADDR, WAIT and DATA, and low in IDLE.
REQ-024 dma_data SHALL hold its value between dma_valid pulses.
REQ-025 mem_addr SHALL be 0 and mem_rd SHALL be 0 outside ADDR.
REQ-026 ptr SHALL increment modulo 2^12: 0xFFF wraps to 0x000.
REQ-027 A 3-bit byte counter SHALL increment on each dma_valid.
REQ-028 line_end SHALL pulse with the dma_valid at which the byte counter wraps 7->0.
REQ-029 ptr_load SHALL set ptr=ptr_value and clear the byte counter on the next edge, in any state.
REQ-030 If ptr_load coincides with the DATA increment, the loaded value SHALL win and the increment SHALL be discarded.
REQ-031 If ptr_load occurs during ADDR or WAIT, the in-flight fetch SHALL complete using its already-issued address.
REQ-032 In that case, DATA SHALL NOT increment the newly loaded pointer.
REQ-033 If clk_enable and dma_req are both high while not in IDLE, overrun SHALL set and remain set until reset.
REQ-034 A request that sets overrun SHALL be dropped and SHALL NOT be queued.

Reset
REQ-035 While resetq=0, the state SHALL be IDLE.
REQ-036 While resetq=0, ptr, the byte counter, dma_data, mem_addr, mem_rd, dma_valid, cpu_stall, line_end and overrun SHALL all be 0.
REQ-037 Reset asserted mid-fetch SHALL abort the fetch, with no dma_valid and no ptr change after release.
REQ-038 The first request after resetq rises SHALL be accepted on the first qualifying clk_enable.

Configuration
REQ-039 The macro DMA_VRAM_WINDOW_EN SHALL select pointer addressing when defined.
REQ-040 When DMA_VRAM_WINDOW_EN is defined, ptr[11:8] SHALL be forced to 0x9 and ptr_value[11:8] SHALL be ignored.
REQ-041 When DMA_VRAM_WINDOW_EN is defined, increment SHALL wrap 0x9FF->0x900.
REQ-042 When DMA_VRAM_WINDOW_EN is defined, the reset value of ptr SHALL be 0x900.
REQ-043 When DMA_VRAM_WINDOW_EN is not defined, ptr SHALL be full 12-bit per REQ-026 and REQ-036.

Verification
REQ-044 Bench SHALL cover: ptr_load 0x900; 8 spaced requests with mem returning addr[7:0] -> dma_data 0x00..0x07, ptr=0x908, line_end only with the 8th dma_valid.
REQ-045 Bench SHALL cover: request accepted at cycle T -> mem_rd at T+1 with mem_addr=ptr, dma_valid at T+3, cpu_stall high T+1..T+3.
REQ-046 Bench SHALL cover (macro undefined): ptr_load 0xFFF then one fetch -> mem_addr 0xFFF, ptr 0x000.
REQ-047 Bench SHALL cover (macro defined): ptr_load 0x3FF then one fetch -> mem_addr 0x9FF, ptr 0x900.
REQ-048 Bench SHALL cover: second qualifying request during WAIT -> overrun=1, only one dma_valid, overrun stays 1 until resetq=0.
REQ-049 Bench SHALL cover: ptr_load 0x950 during WAIT of a fetch from 0x910 -> dma_data=mem[0x910], ptr=0x950 afterward; resetq low in ADDR -> all outputs 0 with no dma_valid.
